// File: rtl/bram_access_pkg.sv
// Shared definitions for the BRAM access sequencer: state encoding and
// default geometry of the attached single-port BRAM.
package bram_access_pkg;

    localparam int DEF_AWIDTH    = 8;
    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_addr_counter.sv
// Up-counter for BRAM addressing; one extra bit so a full-depth block
// can be counted without wrapping. Clear wins over increment.
module bram_addr_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (run_i) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// Writes N streamed words into BRAM addresses 0..N-1, then streams them
// back out; one FSM owns the shared BRAM port.
module bram_access_ctrl
    import bram_access_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [AWIDTH:0]   num_cnt_i,
    input  logic              wr_valid_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic              ce_o,
    output logic              we_o,
    output logic [DWIDTH-1:0] d_o,
    input  logic [DWIDTH-1:0] q_i,
    output logic              idle_o,
    output logic              running_o,
    output logic              done_o
);

    localparam int CW = AWIDTH + 1;

    state_t        state;
    logic [CW-1:0] n_q;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          rd_vld_p1;
    logic          in_wr;
    logic          in_rd;
    logic          wr_hs;
    logic          wr_last;
    logic          rd_last;

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] n);
        return (n > CW'(MEM_DEPTH)) ? CW'(MEM_DEPTH) : n;
    endfunction

    assign in_wr   = (state == S_WRITE);
    assign in_rd   = (state == S_READ);
    assign wr_hs   = in_wr & wr_valid_i;
    assign wr_last = wr_hs && (wr_cnt == n_q - CW'(1));
    assign rd_last = in_rd && (rd_cnt == n_q - CW'(1));

    bram_addr_counter #(.W(CW)) u_wr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .run_i   (wr_hs),
        .clr_i   (wr_last),
        .cnt_o   (wr_cnt)
    );

    bram_addr_counter #(.W(CW)) u_rd_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .run_i   (in_rd),
        .clr_i   (rd_last),
        .cnt_o   (rd_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            n_q       <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            // BRAM returns data one cycle after the read address is issued
            rd_vld_p1 <= in_rd;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (num_cnt_i != '0) begin
                            n_q   <= clamp_count(num_cnt_i);
                            state <= S_WRITE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_WRITE: if (wr_last) state <= S_READ;
                S_READ:  if (rd_last) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign idle_o     = (state == S_IDLE);
    assign running_o  = in_wr | in_rd;
    assign done_o     = (state == S_DONE);
    assign wr_ready_o = in_wr;
    assign ce_o       = wr_hs | in_rd;
    assign we_o       = wr_hs;
    assign addr_o     = in_wr ? wr_cnt[AWIDTH-1:0] :
                        in_rd ? rd_cnt[AWIDTH-1:0] : '0;
    assign d_o        = wr_hs ? wr_data_i : '0;
    assign rd_valid_o = rd_vld_p1;
    assign rd_data_o  = q_i;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Scoreboard bench for bram_access_ctrl with a behavioural BRAM attached.
module tb_bram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [8:0]  num_cnt_i;
    logic        wr_valid_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [7:0]  addr_o;
    logic        ce_o;
    logic        we_o;
    logic [31:0] d_o;
    logic [31:0] q_i;
    logic        idle_o;
    logic        running_o;
    logic        done_o;

    bram_access_ctrl #(.AWIDTH(8), .DWIDTH(32), .MEM_DEPTH(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .num_cnt_i  (num_cnt_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .addr_o     (addr_o),
        .ce_o       (ce_o),
        .we_o       (we_o),
        .d_o        (d_o),
        .q_i        (q_i),
        .idle_o     (idle_o),
        .running_o  (running_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port BRAM, one cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ce_o && we_o)  mem[addr_o] <= d_o;
        if (ce_o && !we_o) q_i <= mem[addr_o];
    end

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_ra[$];
    logic [31:0] exp_rd[$];
    int          exp_done[$];

    int n_total = 0;
    int n_pass  = 0;
    int rd_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_total++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    wr_t mon_w;
    always @(negedge clk) begin
        if (reset_n) begin
            if (ce_o && we_o) begin
                if (exp_wr.size() == 0) fail_evt("unexpected_write");
                else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 64'(addr_o), 64'(mon_w.a));
                    check("wr_data", 64'(d_o), 64'(mon_w.d));
                end
            end
            if (ce_o && !we_o) begin
                rd_seen++;
                if (exp_ra.size() == 0) fail_evt("unexpected_read");
                else check("rd_addr", 64'(addr_o), 64'(exp_ra.pop_front()));
            end
            if (rd_valid_o) begin
                if (exp_rd.size() == 0) fail_evt("unexpected_rd_valid");
                else check("rd_data", 64'(rd_data_o), 64'(exp_rd.pop_front()));
            end
            if (done_o) begin
                if (exp_done.size() == 0) fail_evt("unexpected_done");
                else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
            end
        end
    end

    task automatic chk_reset_outputs();
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_outs", 64'({running_o, done_o, wr_ready_o, rd_valid_o, ce_o, we_o, addr_o, d_o}), 64'd0);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done_o && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (!done_o) fail_evt("done_timeout");
        else begin
            @(posedge clk); #1;
            check("idle_after_done", 64'(idle_o), 64'd1);
        end
    endtask

    // mode: 0 continuous valid, 1 alternating 1,0,1,..., 2 random
    task automatic transfer(input int n_req, input int mode, input bit fixed, input bit poke);
        int n = (n_req > 256) ? 256 : n_req;
        int k = 0;
        int it = 0;
        int h;
        bit poked = 0;
        logic [31:0] dat;
        logic v;
        start_i   = 1'b1;
        num_cnt_i = 9'(n_req);
        h = cyc;
        if (n == 0) exp_done.push_back(cyc + 1);
        @(posedge clk); #1;
        start_i = 1'b0;
        while (k < n && it < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((it % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (poke && !poked && k == 1) begin
                start_i   = 1'b1;
                num_cnt_i = 9'($urandom_range(0, 511));
                poked     = 1'b1;
            end
            dat = fixed ? 32'hA0 + 32'(k) : $urandom;
            wr_valid_i = v;
            wr_data_i  = dat;
            if (v) begin
                exp_wr.push_back('{a: 8'(k), d: dat});
                exp_ra.push_back(8'(k));
                exp_rd.push_back(dat);
                h = cyc;
                k++;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            it++;
        end
        wr_valid_i = 1'b0;
        if (n > 0) begin
            exp_done.push_back(h + n + 1);
            if (poke) begin
                start_i   = 1'b1;
                num_cnt_i = 9'($urandom_range(1, 511));
                @(posedge clk); #1;
                start_i = 1'b0;
            end
        end
        wait_done();
    endtask

    task automatic abort_mid_read();
        int base;
        int g = 0;
        start_i   = 1'b1;
        num_cnt_i = 9'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        base = rd_seen;
        for (int k = 0; k < 4; k++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = $urandom;
            exp_wr.push_back('{a: 8'(k), d: wr_data_i});
            exp_ra.push_back(8'(k));
            exp_rd.push_back(wr_data_i);
            @(posedge clk); #1;
        end
        wr_valid_i = 1'b0;
        while (rd_seen < base + 2 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (rd_seen < base + 2) fail_evt("abort_read_timeout");
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs();
        exp_wr.delete();
        exp_ra.delete();
        exp_rd.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        start_i    = 1'b0;
        num_cnt_i  = '0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        transfer(4, 0, 1'b1, 1'b0);
        transfer(3, 1, 1'b0, 1'b0);
        transfer(0, 0, 1'b0, 1'b0);
        transfer(300, 0, 1'b0, 1'b0);
        transfer(1, 0, 1'b0, 1'b0);
        transfer(6, 2, 1'b0, 1'b1);
        abort_mid_read();
        transfer(2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            transfer($urandom_range(1, 24), 2, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 64'(idle_o), 64'd1);
        check("leftover_writes", 64'(exp_wr.size()), 64'd0);
        check("leftover_reads", 64'(exp_ra.size()), 64'd0);
        check("leftover_rdata", 64'(exp_rd.size()), 64'd0);
        check("leftover_done", 64'(exp_done.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bram_access_ctrl.md
Name: bram_access_ctrl

Overview:
Sequencer for a single-port BRAM. It writes a block of N words from an upstream valid/ready stream into BRAM addresses 0..N-1, then reads the same N words back as an output stream. One 4-state FSM owns the shared BRAM port and drives two internal address counters (write, read). It sits between the data source/sink and the BRAM macro in the bram_accessor subsystem.

Parameters:
AWIDTH, 8, BRAM address width
DWIDTH, 32, BRAM data width
MEM_DEPTH, 256, number of BRAM words; must equal 2**AWIDTH

Ports:
clk  input  1  single clock; all flops on rising edge
reset_n  input  1  asynchronous, active-low reset
start_i  input  1  one-cycle pulse; starts a transfer when sampled in IDLE
num_cnt_i  input  AWIDTH+1  word count N; sampled with start_i
wr_valid_i  input  1  upstream write data valid
wr_data_i  input  DWIDTH  upstream write data
wr_ready_o  output  1  write data accepted when wr_valid_i & wr_ready_o
rd_valid_o  output  1  rd_data_o valid this cycle (no backpressure)
rd_data_o  output  DWIDTH  read data, combinational pass of q_i
addr_o  output  AWIDTH  BRAM address
ce_o  output  1  BRAM chip enable
we_o  output  1  BRAM write enable
d_o  output  DWIDTH  BRAM write data
q_i  input  DWIDTH  BRAM read data, 1-cycle latency after ce_o & !we_o
idle_o  output  1  FSM in IDLE
running_o  output  1  FSM in WRITE or READ
done_o  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (async, immediate): state=IDLE, both counters=0, latched count=0, rd_valid delay flop=0. Outputs then read idle_o=1 and all others 0.
- States: IDLE=0, WRITE=1, READ=2, DONE=3 (2-bit).
- IDLE:
  - start_i & num_cnt_i!=0 -> latch N and go to WRITE.
  - start_i & num_cnt_i==0 -> go to DONE.
  - N > MEM_DEPTH is clamped to MEM_DEPTH.
  - start_i is ignored in every other state.
- WRITE:
  - wr_ready_o=1.
  - On handshake: ce_o=1, we_o=1, addr_o=wr_cnt, d_o=wr_data_i (same cycle, combinational), and wr_cnt increments.
  - No handshake: ce_o=0 and wr_cnt holds.
  - Handshake with wr_cnt==N-1 -> go to READ and clear wr_cnt.
- READ:
  - Every cycle: ce_o=1, we_o=0, addr_o=rd_cnt, and rd_cnt increments. No stalls.
  - When rd_cnt==N-1 -> go to DONE and clear rd_cnt.
- rd_valid_o = registered (state==READ). It is high exactly N cycles, lagging the address issue by 1 cycle, so the last word is valid during DONE.
- rd_data_o = q_i.
- DONE: done_o=1 for exactly one cycle -> go to IDLE.
- Outside WRITE/READ: ce_o=0, we_o=0, addr_o=0, d_o=0, wr_ready_o=0.
- Counters are AWIDTH+1 bits internally so N=256 works. addr_o takes the low AWIDTH bits; no wrap occurs within a transfer.
- Reset mid-transfer aborts with no completion pulse. BRAM contents already written are undefined to the controller.
- Total latency for N words with continuous wr_valid_i: start to done_o = N (WRITE) + N (READ) + 1 cycles.

Decomposition:
- Shared package bram_access_pkg holds:
  - state encoding localparams S_IDLE, S_WRITE, S_READ, S_DONE
  - default AWIDTH/DWIDTH/MEM_DEPTH constants
- One sub-module, bram_addr_counter: AWIDTH+1-bit counter with run_i (increment) and clr_i (synchronous clear, clr_i has priority), async active-low reset.
  - Instantiated twice: write and read.

Test Plan:
- Reset then start_i with N=4, wr_valid_i held high, data 0xA0..0xA3:
  - BRAM writes to addr 0..3 on cycles 1..4.
  - Reads of addr 0..3 on cycles 5..8; rd_valid_o high cycles 6..9 returning 0xA0..0xA3.
  - done_o pulses on cycle 9; idle_o=1 on cycle 10.
- N=3 with wr_valid_i toggling 1,0,1,0,1:
  - Exactly 3 writes, to addr 0,1,2.
  - ce_o=0 on the idle cycles; READ is entered only after the third handshake.
- N=0: done_o pulses on the cycle after start, with no ce_o activity. N=300: exactly 256 writes, addr_o wraps from 255 to READ at addr 0.
- start_i pulsed during WRITE and during READ: ignored; the transfer in progress is unaffected and no second done_o pulse occurs.
- reset_n low mid-READ (after 2 of 4 reads):
  - All outputs drop to reset values asynchronously, with no done_o.
  - A new start_i with N=2 afterwards writes from addr 0 again.
- Back-to-back: start_i asserted the cycle idle_o returns to 1 is accepted. The second transfer restarts both counters at 0.
